// File: rtl/vx_flush_if.sv
// vx_flush_if
// Flush request/response handshake between a flush requester and vx_flush_unit.
//   flush_req_valid / flush_req_tag / flush_req_ready : flush request channel
//   flush_rsp_valid / flush_rsp_tag / flush_rsp_ready : flush completion channel
// Modports: master = requester side, slave = flush unit side.
interface vx_flush_if #(
  parameter int TAG_WIDTH = 4
) ();
  logic                 flush_req_valid;
  logic [TAG_WIDTH-1:0] flush_req_tag;
  logic                 flush_req_ready;
  logic                 flush_rsp_valid;
  logic [TAG_WIDTH-1:0] flush_rsp_tag;
  logic                 flush_rsp_ready;

  modport master (
    output flush_req_valid,
    output flush_req_tag,
    input  flush_req_ready,
    input  flush_rsp_valid,
    input  flush_rsp_tag,
    output flush_rsp_ready
  );

  modport slave (
    input  flush_req_valid,
    input  flush_req_tag,
    output flush_req_ready,
    output flush_rsp_valid,
    output flush_rsp_tag,
    input  flush_rsp_ready
  );
endinterface

// File: rtl/vx_flush_unit.sv
// vx_flush_unit
// Cache flush sequencer: drains in-flight core requests, then walks every
// line index issuing invalidates to the tag store, then reports completion.
// After reset it runs the same sweep on its own (init sweep) with no response.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   flush_if (slave)     : flush request / response handshake
//   core_req_fire        : core request entered the cache (pending +1)
//   core_rsp_fire        : core request retired (pending -1)
//   core_req_stall       : blocks new core requests while not idle
//   inv_valid/inv_addr   : invalidate request for line inv_addr
//   inv_ready            : tag store accepted the invalidate
//   busy                 : unit is not idle
//   perf_flush_cycles    : only with VX_FLUSH_PERF_EN; cycles spent in
//                          requested flushes (init sweeps excluded)
//
// Optional feature macro: VX_FLUSH_PERF_EN
//
// state | meaning
// IDLE  | ready for a flush request
// DRAIN | waiting for all pending core requests to retire
// SWEEP | issuing invalidates for line indices 0..LINES-1
// RESP  | presenting flush completion until consumed
module vx_flush_unit #(
  parameter int  CACHE_SIZE      = 16384,
  parameter int  CACHE_LINE_SIZE = 1,
  parameter int  NUM_BANKS       = 1,
  parameter int  TAG_WIDTH       = 4,
  parameter int  MAX_PENDING     = 8,
  localparam int LINES = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
  localparam int LSB   = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int PW    = $clog2(MAX_PENDING + 1)
) (
  input  logic           clk,
  input  logic           reset,
  vx_flush_if.slave      flush_if,
  input  logic           core_req_fire,
  input  logic           core_rsp_fire,
  output logic           core_req_stall,
  output logic           inv_valid,
  output logic [LSB-1:0] inv_addr,
  input  logic           inv_ready,
  output logic           busy
`ifdef VX_FLUSH_PERF_EN
  ,
  output logic [31:0]    perf_flush_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [LSB-1:0] LAST_IDX = LSB'(LINES - 1);

  state_t               state_q, state_d;
  logic                 init_q, init_d;
  logic [LSB-1:0]       addr_q, addr_d;
  logic [PW-1:0]        pending_q, pending_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  always_comb begin
    pending_d = pending_q;
    case ({core_req_fire, core_rsp_fire})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    addr_d  = addr_q;
    tag_d   = tag_q;

    flush_if.flush_req_ready = (state_q == ST_IDLE);
    flush_if.flush_rsp_valid = (state_q == ST_RESP);
    flush_if.flush_rsp_tag   = tag_q;
    inv_valid                = (state_q == ST_SWEEP);
    inv_addr                 = addr_q;
    core_req_stall           = (state_q != ST_IDLE);
    busy                     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (flush_if.flush_req_valid) begin
          tag_d   = flush_if.flush_req_tag;
          init_d  = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Look at the post-update count so a retire in this cycle ends the drain.
        if (pending_d == '0) begin
          addr_d  = '0;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (inv_ready) begin
          if (addr_q == LAST_IDX) begin
            addr_d  = '0;
            state_d = init_q ? ST_IDLE : ST_RESP;
          end else begin
            addr_d = addr_q + LSB'(1);
          end
        end
      end
      ST_RESP: begin
        if (flush_if.flush_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset already shows the init sweep's first invalidate before the
    // state register has been loaded.
    if (reset) begin
      flush_if.flush_req_ready = 1'b0;
      flush_if.flush_rsp_valid = 1'b0;
      inv_valid                = 1'b1;
      inv_addr                 = '0;
      core_req_stall           = 1'b1;
      busy                     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SWEEP;
      init_q    <= 1'b1;
      addr_q    <= '0;
      pending_q <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      tag_q     <= tag_d;
    end
  end

`ifdef VX_FLUSH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q != ST_IDLE) && !init_q) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_flush_cycles = perf_q;
`endif

`ifndef SYNTHESIS
  a_pending_overflow: assert property (@(posedge clk) disable iff (reset)
    !(core_req_fire && !core_rsp_fire && (pending_q == PW'(MAX_PENDING))));
  a_pending_underflow: assert property (@(posedge clk) disable iff (reset)
    !(core_rsp_fire && !core_req_fire && (pending_q == '0)));
`endif

endmodule

// File: tb/tb_vx_flush_unit.sv
// Scoreboard bench for vx_flush_unit with a 64-line configuration.
module tb_vx_flush_unit;
  localparam int LINES = 64;
  localparam int LSB   = 6;

  typedef struct {
    logic [3:0] tag;
    int         lat;
  } rsp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           core_req_fire;
  logic           core_rsp_fire;
  logic           core_req_stall;
  logic           inv_valid;
  logic [LSB-1:0] inv_addr;
  logic           inv_ready;
  logic           busy;
`ifdef VX_FLUSH_PERF_EN
  logic [31:0]    perf_flush_cycles;
`endif

  vx_flush_if #(.TAG_WIDTH(4)) fif ();

  vx_flush_unit #(
    .CACHE_SIZE(1024),
    .CACHE_LINE_SIZE(16),
    .NUM_BANKS(1),
    .TAG_WIDTH(4),
    .MAX_PENDING(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush_if(fif),
    .core_req_fire(core_req_fire),
    .core_rsp_fire(core_rsp_fire),
    .core_req_stall(core_req_stall),
    .inv_valid(inv_valid),
    .inv_addr(inv_addr),
    .inv_ready(inv_ready),
    .busy(busy)
`ifdef VX_FLUSH_PERF_EN
    ,
    .perf_flush_cycles(perf_flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int   inv_q[$];
  rsp_t rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake.
  logic           inv_hold = 1'b0;
  logic [LSB-1:0] inv_hold_addr = '0;
  logic           rsp_hold = 1'b0;
  logic [3:0]     rsp_hold_tag = '0;
  int             acc_cyc = 0;
  int             e_idx;
  rsp_t           e_rsp;

  always @(negedge clk) begin
    if (!reset) begin
      if (inv_hold) begin
        chk("inv_stall_valid", 32'(inv_valid), 32'd1);
        chk("inv_stall_addr", 32'(inv_addr), 32'(inv_hold_addr));
      end
      if (inv_valid && inv_ready) begin
        if (inv_q.size() == 0) begin
          fail_now($sformatf("inv_extra: index %0d issued, none expected", inv_addr));
        end else begin
          e_idx = inv_q.pop_front();
          chk("inv_index", 32'(inv_addr), 32'(e_idx));
        end
      end
      inv_hold      <= inv_valid && !inv_ready;
      inv_hold_addr <= inv_addr;

      if (rsp_hold) begin
        chk("rsp_hold_valid", 32'(fif.flush_rsp_valid), 32'd1);
        chk("rsp_hold_tag", 32'(fif.flush_rsp_tag), 32'(rsp_hold_tag));
      end
      if (fif.flush_req_valid && fif.flush_req_ready) begin
        acc_cyc <= cyc;
      end
      if (fif.flush_rsp_valid && fif.flush_rsp_ready) begin
        if (rsp_q.size() == 0) begin
          fail_now($sformatf("rsp_extra: tag %0d returned, none expected", fif.flush_rsp_tag));
        end else begin
          e_rsp = rsp_q.pop_front();
          chk("rsp_tag", 32'(fif.flush_rsp_tag), 32'(e_rsp.tag));
          if (e_rsp.lat >= 0) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e_rsp.lat));
        end
      end
      rsp_hold     <= fif.flush_rsp_valid && !fif.flush_rsp_ready;
      rsp_hold_tag <= fif.flush_rsp_tag;
    end else begin
      inv_hold <= 1'b0;
      rsp_hold <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) inv_q.push_back(i);
  endtask

  task automatic wait_idle(input string name, input bit toggle);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (fif.flush_req_ready && rsp_q.size() == 0 && inv_q.size() == 0) done = 1'b1;
      else begin
        if (toggle) inv_ready = ~inv_ready;
        tick();
      end
    end
    if (!done) fail_now($sformatf("%s: timeout, inv left %0d rsp left %0d", name, inv_q.size(), rsp_q.size()));
    else chk({name, "_drained"}, 32'(inv_q.size() + rsp_q.size()), 32'd0);
    inv_ready = 1'b1;
  endtask

  task automatic issue_flush(input logic [3:0] tag);
    fif.flush_req_valid = 1'b1;
    fif.flush_req_tag   = tag;
    tick();
    fif.flush_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    core_req_fire       = 1'b0;
    core_rsp_fire       = 1'b0;
    inv_ready           = 1'b1;
    fif.flush_req_valid = 1'b0;
    fif.flush_req_tag   = '0;
    fif.flush_rsp_ready = 1'b1;

    // Reset and init sweep
    tick(); tick(); tick();
    chk("rst_inv_valid", 32'(inv_valid), 32'd1);
    chk("rst_inv_addr", 32'(inv_addr), 32'd0);
    chk("rst_req_ready", 32'(fif.flush_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(fif.flush_rsp_valid), 32'd0);
    chk("rst_stall", 32'(core_req_stall), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    push_sweep(LINES);
    reset = 1'b0;
    chk("post_rst_inv_valid", 32'(inv_valid), 32'd1);
    chk("post_rst_inv_addr", 32'(inv_addr), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd1);
    for (int i = 0; i < LINES - 1; i++) tick();
    chk("init_last_ready", 32'(fif.flush_req_ready), 32'd0);
    chk("init_last_addr", 32'(inv_addr), 32'(LINES - 1));
    tick();
    chk("init_done_ready", 32'(fif.flush_req_ready), 32'd1);
    chk("init_done_busy", 32'(busy), 32'd0);
    chk("init_done_stall", 32'(core_req_stall), 32'd0);
    chk("init_done_inv_valid", 32'(inv_valid), 32'd0);
    wait_idle("init", 1'b0);

    // Ideal-latency flush
    push_sweep(LINES);
    rsp_q.push_back('{tag: 4'h5, lat: 66});
    issue_flush(4'h5);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_req_ready", 32'(fif.flush_req_ready), 32'd0);
    wait_idle("flush5", 1'b0);
`ifdef VX_FLUSH_PERF_EN
    chk("perf_cycles", perf_flush_cycles, 32'd66);
`endif

    // Pending core requests hold off the sweep (one fires in the accept cycle)
    push_sweep(LINES);
    rsp_q.push_back('{tag: 4'h7, lat: -1});
    core_req_fire = 1'b1;
    tick(); tick();
    fif.flush_req_valid = 1'b1;
    fif.flush_req_tag   = 4'h7;
    tick();
    fif.flush_req_valid = 1'b0;
    core_req_fire       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_no_inv", 32'(inv_valid), 32'd0);
      chk("drain_stall", 32'(core_req_stall), 32'd1);
      tick();
    end
    for (int r = 0; r < 3; r++) begin
      chk("drain_no_inv_rsp", 32'(inv_valid), 32'd0);
      core_rsp_fire = 1'b1;
      tick();
      core_rsp_fire = 1'b0;
    end
    chk("sweep_start_valid", 32'(inv_valid), 32'd1);
    chk("sweep_start_addr", 32'(inv_addr), 32'd0);
    wait_idle("flush7", 1'b0);

    // Invalidate backpressure toggling every cycle
    push_sweep(LINES);
    rsp_q.push_back('{tag: 4'hC, lat: -1});
    issue_flush(4'hC);
    wait_idle("flushC_toggle", 1'b1);

    // Response backpressure; request held high outside IDLE must be ignored
    fif.flush_rsp_ready = 1'b0;
    push_sweep(LINES);
    rsp_q.push_back('{tag: 4'h2, lat: -1});
    issue_flush(4'h2);
    fif.flush_req_valid = 1'b1;
    fif.flush_req_tag   = 4'hF;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (fif.flush_rsp_valid) seen = 1'b1;
        else tick();
      end
      if (!seen) fail_now("rsp_wait: timeout waiting for flush_rsp_valid");
    end
    fif.flush_req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_rsp_valid", 32'(fif.flush_rsp_valid), 32'd1);
      chk("hold_rsp_tag", 32'(fif.flush_rsp_tag), 32'h2);
      chk("hold_req_ready", 32'(fif.flush_req_ready), 32'd0);
      chk("hold_stall", 32'(core_req_stall), 32'd1);
      tick();
    end
    fif.flush_rsp_ready = 1'b1;
    wait_idle("flush2", 1'b0);
    chk("after2_ready", 32'(fif.flush_req_ready), 32'd1);

    // Reset in the middle of a sweep abandons the flush
    push_sweep(20);
    issue_flush(4'hA);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        if (inv_valid && inv_addr == 6'd20) hit = 1'b1;
        else tick();
      end
      if (!hit) fail_now("midreset_wait: sweep never reached index 20");
    end
    inv_ready = 1'b0;
    reset     = 1'b1;
    tick(); tick();
    chk("midrst_q_empty", 32'(inv_q.size()), 32'd0);
    push_sweep(LINES);
    reset     = 1'b0;
    inv_ready = 1'b1;
    chk("midrst_inv_valid", 32'(inv_valid), 32'd1);
    chk("midrst_inv_addr", 32'(inv_addr), 32'd0);
    wait_idle("midreset", 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_rsp", 32'(fif.flush_rsp_valid), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
